multicycle_sequencer: RTL and testbench

- Multi-cycle control FSM that sequences the single-ported datapath through the steps FETCH, DECODE, EXEC, MEM and WB.
- Shares one memory port between instruction fetch and load/store using a req/ready handshake.
- Drives the register file, ALU and memory control lines per step, using the same opcode map as the combinational decoder (R-type 7'h00, LW 7'h08, SW 7'h10).
- Sits between the instruction register and the datapath muxes/enables.

---
 rtl/multicycle_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_sequencer                                         |
// | Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM sharing one |
// |               memory port; optional perf counters under PERF_CNT_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic             mdr_write,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             wb_sel,
    output logic             busy,
    output logic             halted,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic [2:0]       state_dbg,
    output logic [CNT_W-1:0] instr_retired,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_decode = 3'd2;
    localparam logic [2:0] c_st_exec   = 3'd3;
    localparam logic [2:0] c_st_mem    = 3'd4;
    localparam logic [2:0] c_st_wb     = 3'd5;
    localparam logic [2:0] c_st_halt   = 3'd6;

    localparam logic [6:0] c_op_r  = 7'h00;
    localparam logic [6:0] c_op_lw = 7'h08;
    localparam logic [6:0] c_op_sw = 7'h10;

    localparam int c_to_w = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [c_to_w-1:0] c_to_last =
        c_to_w'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [6:0]        r_op;
    logic              r_err_illegal;
    logic              r_err_timeout;
    logic [c_to_w-1:0] r_to_cnt;
    logic              w_wait;
    logic              w_to_hit;
    logic              w_retire;
    logic              w_set_ill;
    logic              w_set_to;

    // A wait cycle is any cycle the shared memory port is requested but not served.
    assign w_wait   = ((r_state == c_st_fetch) || (r_state == c_st_mem)) && !mem_ready;
    assign w_to_hit = (MEM_TIMEOUT != 0) && w_wait && (r_to_cnt == c_to_last);

    assign state_dbg   = r_state;
    assign err_illegal = r_err_illegal;
    assign err_timeout = r_err_timeout;

    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        w_set_ill    = 1'b0;
        w_set_to     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        mdr_write    = 1'b0;
        alu_op       = 2'b00;
        reg_write    = 1'b0;
        wb_sel       = 1'b0;
        busy         = 1'b0;
        halted       = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (run) begin
                    w_next = c_st_fetch;
                end
            end
            c_st_fetch: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = c_st_decode;
                end else if (w_to_hit) begin
                    w_set_to = 1'b1;
                    w_next   = c_st_halt;
                end
            end
            c_st_decode: begin
                busy = 1'b1;
                case (opcode)
                    c_op_r, c_op_lw, c_op_sw: w_next = c_st_exec;
                    default: begin
                        w_set_ill = 1'b1;
                        w_next    = c_st_halt;
                    end
                endcase
            end
            c_st_exec: begin
                busy   = 1'b1;
                alu_op = (r_op == c_op_r) ? 2'b10 : 2'b00;
                w_next = (r_op == c_op_r) ? c_st_wb : c_st_mem;
            end
            c_st_mem: begin
                busy         = 1'b1;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (r_op == c_op_sw);
                if (mem_ready) begin
                    if (r_op == c_op_lw) begin
                        mdr_write = 1'b1;
                        w_next    = c_st_wb;
                    end else begin
                        w_retire = 1'b1;
                    end
                end else if (w_to_hit) begin
                    w_set_to = 1'b1;
                    w_next   = c_st_halt;
                end
            end
            c_st_wb: begin
                busy      = 1'b1;
                reg_write = 1'b1;
                wb_sel    = (r_op == c_op_lw);
                w_retire  = 1'b1;
            end
            c_st_halt: begin
                halted = 1'b1;
            end
            default: begin
                w_next = c_st_idle;
            end
        endcase

        // Retire point: run decides between the next fetch and parking in IDLE.
        if (w_retire) begin
            w_next = run ? c_st_fetch : c_st_idle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_op          <= '0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
            r_to_cnt      <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == c_st_decode) begin
                r_op <= opcode;
            end
            if (w_set_ill) begin
                r_err_illegal <= 1'b1;
            end
            if (w_set_to) begin
                r_err_timeout <= 1'b1;
            end
            // Any state change restarts the wait count, covering entry to FETCH and MEM.
            if (w_next != r_state) begin
                r_to_cnt <= '0;
            end else if (w_wait) begin
                r_to_cnt <= r_to_cnt + c_to_w'(1);
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_instr_retired;
    logic [CNT_W-1:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_retired <= '0;
            r_stall_cycles  <= '0;
        end else begin
            if (w_retire) begin
                r_instr_retired <= r_instr_retired + CNT_W'(1);
            end
            if (w_wait) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

    assign instr_retired = r_instr_retired;
    assign stall_cycles  = r_stall_cycles;
`else
    assign instr_retired = '0;
    assign stall_cycles  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multicycle_sequencer                                      |
// | Description : Trace-model bench: builds per-instruction cycle expectations |
// |               from opcode and wait counts, replays and compares each cycle.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_multicycle_sequencer;

    localparam int CW = 4;
    localparam int TO = 15;
    localparam logic [6:0] OP_R  = 7'h00;
    localparam logic [6:0] OP_LW = 7'h08;
    localparam logic [6:0] OP_SW = 7'h10;
`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [6:0]    opcode;
    logic          mem_ready;
    logic          mem_req, mem_we, mem_addr_sel, ir_write, pc_write, mdr_write;
    logic [1:0]    alu_op;
    logic          reg_write, wb_sel, busy, halted, err_illegal, err_timeout;
    logic [2:0]    state_dbg;
    logic [CW-1:0] instr_retired, stall_cycles;

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .mdr_write(mdr_write),
        .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel), .busy(busy),
        .halted(halted), .err_illegal(err_illegal), .err_timeout(err_timeout),
        .state_dbg(state_dbg), .instr_retired(instr_retired), .stall_cycles(stall_cycles)
    );

    typedef struct {
        logic          rst;
        logic          run;
        logic [6:0]    op;
        logic          rdy;
        bit            chk;
        logic [16:0]   ev;
        logic [CW-1:0] ret;
        logic [CW-1:0] stl;
    } step_t;

    step_t         trace[$];
    step_t         cur;
    bit            cur_valid = 1'b0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            cyc = 0;
    logic          m_ill, m_to;
    logic [CW-1:0] m_ret, m_stl;

    // Control vector order: req, we, addr_sel, ir_write, pc_write, mdr_write, alu_op, reg_write, wb_sel.
    function automatic logic [9:0] ctl(input logic req, input logic we, input logic sel,
                                       input logic ir, input logic pc, input logic mdr,
                                       input logic [1:0] alu, input logic rw, input logic wb);
        return {req, we, sel, ir, pc, mdr, alu, rw, wb};
    endfunction

    task automatic push(input logic r, input logic rn, input logic [6:0] op, input logic rdy,
                        input bit chk, input logic [2:0] st, input logic [9:0] c);
        step_t s;
        s.rst = r; s.run = rn; s.op = op; s.rdy = rdy; s.chk = chk;
        s.ev  = {st, c, (st != 3'd0 && st != 3'd6), (st == 3'd6), m_ill, m_to};
        s.ret = m_ret;
        s.stl = m_stl;
        trace.push_back(s);
    endtask

    task automatic gen_reset();
        push(1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 3'd0, 10'd0);
        m_ill = 1'b0; m_to = 1'b0; m_ret = '0; m_stl = '0;
    endtask

    task automatic gen_idle(input int n, input logic rn);
        for (int i = 0; i < n; i++) push(1'b0, rn, 7'h00, 1'b0, 1'b1, 3'd0, 10'd0);
    endtask

    task automatic gen_halt(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b1, 7'h00, logic'(i % 2), 1'b1, 3'd6, 10'd0);
    endtask

    // One instruction as the sequencer must walk it: fw/mw are memory wait cycles.
    task automatic gen_instr(input logic [6:0] op, input int fw, input int mw, input logic run_ret);
        logic [9:0] mem_c;
        for (int i = 0; i < fw && i < TO; i++) begin
            push(1'b0, 1'b1, op, 1'b0, 1'b1, 3'd1, ctl(1,0,0,0,0,0,2'b00,0,0));
            m_stl++;
        end
        if (fw >= TO) begin m_to = 1'b1; return; end
        push(1'b0, 1'b1, op, 1'b1, 1'b1, 3'd1, ctl(1,0,0,1,1,0,2'b00,0,0));
        push(1'b0, 1'b1, op, 1'b0, 1'b1, 3'd2, 10'd0);
        if (op != OP_R && op != OP_LW && op != OP_SW) begin m_ill = 1'b1; return; end
        push(1'b0, 1'b1, op, 1'b0, 1'b1, 3'd3, ctl(0,0,0,0,0,0,(op == OP_R) ? 2'b10 : 2'b00,0,0));
        if (op == OP_R) begin
            push(1'b0, run_ret, op, 1'b0, 1'b1, 3'd5, ctl(0,0,0,0,0,0,2'b00,1,0));
            m_ret++;
            return;
        end
        mem_c = ctl(1, (op == OP_SW), 1, 0, 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < mw && i < TO; i++) begin
            push(1'b0, 1'b1, op, 1'b0, 1'b1, 3'd4, mem_c);
            m_stl++;
        end
        if (mw >= TO) begin m_to = 1'b1; return; end
        if (op == OP_SW) begin
            push(1'b0, run_ret, op, 1'b1, 1'b1, 3'd4, mem_c);
            m_ret++;
            return;
        end
        push(1'b0, 1'b1, op, 1'b1, 1'b1, 3'd4, ctl(1,0,1,0,0,1,2'b00,0,0));
        push(1'b0, run_ret, op, 1'b0, 1'b1, 3'd5, ctl(0,0,0,0,0,0,2'b00,1,1));
        m_ret++;
    endtask

    task automatic play();
        step_t s;
        while (trace.size() > 0) begin
            s = trace.pop_front();
            rst = s.rst; run = s.run; opcode = s.op; mem_ready = s.rdy;
            cur = s;
            cur_valid = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        cur_valid = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [16:0]   act;
        logic [CW-1:0] eret, estl;
        if (cur_valid && cur.chk) begin
            act = {state_dbg, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, mdr_write,
                   alu_op, reg_write, wb_sel, busy, halted, err_illegal, err_timeout};
            n_tests++;
            if (act !== cur.ev) begin
                n_fail++;
                $display("FAIL cycle %0d outputs: got %b expected %b", cyc, act, cur.ev);
            end
            eret = PERF ? cur.ret : '0;
            estl = PERF ? cur.stl : '0;
            n_tests++;
            if (instr_retired !== eret || stall_cycles !== estl) begin
                n_fail++;
                $display("FAIL cycle %0d perf: got ret=%0d stall=%0d expected ret=%0d stall=%0d",
                         cyc, instr_retired, stall_cycles, eret, estl);
            end
        end
    end

    initial begin
        int base;
        rst = 1'b1; run = 1'b0; opcode = 7'h00; mem_ready = 1'b0;
        m_ill = 1'b0; m_to = 1'b0; m_ret = '0; m_stl = '0;
        @(posedge clk); #1;

        // Zero-wait R, LW, SW back to back; lengths pin the model's minimum latencies.
        gen_reset(); gen_idle(2, 1'b0); gen_idle(1, 1'b1);
        base = trace.size(); gen_instr(OP_R, 0, 0, 1'b1);  chk("rtype_latency", trace.size() - base, 4);
        base = trace.size(); gen_instr(OP_LW, 0, 0, 1'b1); chk("lw_latency", trace.size() - base, 5);
        base = trace.size(); gen_instr(OP_SW, 0, 0, 1'b0); chk("sw_latency", trace.size() - base, 4);
        gen_idle(3, 1'b0);
        play();
        chk("idle_after_run_drop", state_dbg, 0);
        chk("retired_three", instr_retired, PERF ? 3 : 0);

        // LW with fetch and memory waits, then SW with waits followed by R.
        gen_reset(); gen_idle(1, 1'b1);
        gen_instr(OP_LW, 2, 3, 1'b1);
        gen_instr(OP_SW, 1, 2, 1'b1);
        gen_instr(OP_R, 0, 0, 1'b0);
        gen_idle(2, 1'b0);
        play();
        chk("stall_total", stall_cycles, PERF ? 8 : 0);

        // Illegal opcode parks in HALT until reset.
        gen_reset(); gen_idle(1, 1'b1);
        gen_instr(7'h7F, 0, 0, 1'b1);
        gen_halt(20);
        play();
        chk("illegal_halt_state", state_dbg, 6);
        chk("illegal_flag", err_illegal, 1);
        chk("illegal_busy", busy, 0);
        gen_reset(); gen_idle(2, 1'b0);
        play();
        chk("illegal_cleared", err_illegal, 0);

        // Fetch timeout after 15 waits; then ready exactly on the limit cycle in FETCH and MEM.
        gen_reset(); gen_idle(1, 1'b1);
        gen_instr(OP_R, TO, 0, 1'b1);
        gen_halt(5);
        play();
        chk("timeout_flag", err_timeout, 1);
        chk("timeout_mem_req", mem_req, 0);
        gen_reset(); gen_idle(1, 1'b1);
        gen_instr(OP_R, TO - 1, 0, 1'b1);
        gen_instr(OP_LW, 0, TO - 1, 1'b0);
        gen_idle(2, 1'b0);
        play();
        chk("ready_wins_no_error", err_timeout, 0);
        gen_reset(); gen_idle(1, 1'b1);
        gen_instr(OP_SW, 0, TO, 1'b1);
        gen_halt(3);
        play();
        chk("mem_timeout_halt", state_dbg, 6);

        // Reset in the middle of an LW memory wait.
        gen_reset(); gen_idle(1, 1'b1);
        base = trace.size();
        gen_instr(OP_LW, 0, 2, 1'b1);
        while (trace.size() > base + 4) void'(trace.pop_back());
        gen_reset(); gen_idle(2, 1'b0);
        play();
        chk("abort_idle", state_dbg, 0);

        // Seventeen retires wrap a 4-bit retire counter to 1.
        gen_reset(); gen_idle(1, 1'b1);
        for (int i = 0; i < 17; i++) begin
            gen_instr((i % 3 == 0) ? OP_R : ((i % 3 == 1) ? OP_LW : OP_SW), 0, 0, (i != 16));
        end
        gen_idle(2, 1'b0);
        play();
        chk("retire_wrap", instr_retired, PERF ? 1 : 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
